cpu_core: RTL and testbench



---
 rtl/cpu_core.sv | 174 +++++++++++++++++
 tb/tb_cpu_core.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/cpu_core.sv
// rtl/cpu_core.sv - 8-bit 6502-subset core with its single-port synchronous RAM
// Core runs FETCH/DECODE/EXEC; RAM reads are registered (one-cycle latency).

module core #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        RW,
  output logic [15:0] AD,
  input  logic [7:0]  D_in,
  output logic [7:0]  D_out
);

  typedef enum logic [1:0] {FETCH, DECODE, EXEC} state_t;

  state_t      state, state_nx;
  logic [15:0] pc, pc_nx;
  logic [7:0]  a, a_nx, ir, ir_nx;
  logic        c_flag, z_flag, n_flag, v_flag;
  logic        c_nx, z_nx, n_nx, v_nx;
  logic [7:0]  opb, res;
  logic [8:0]  sum, diff;
  logic        set_nz;

  function automatic logic two_byte(input logic [7:0] op);
    case (op)
      8'hA9, 8'h69, 8'hE9, 8'h29, 8'h09, 8'h49, 8'hC9, 8'h85: two_byte = 1'b1;
      default: two_byte = 1'b0;
    endcase
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= FETCH;
      pc     <= RESET_PC;
      a      <= 8'h00;
      ir     <= 8'h00;
      c_flag <= 1'b0;
      z_flag <= 1'b0;
      n_flag <= 1'b0;
      v_flag <= 1'b0;
    end else begin
      state  <= state_nx;
      pc     <= pc_nx;
      a      <= a_nx;
      ir     <= ir_nx;
      c_flag <= c_nx;
      z_flag <= z_nx;
      n_flag <= n_nx;
      v_flag <= v_nx;
    end
  end

  // SBC reuses the ADC adder with the operand inverted; CMP uses a separate borrow path.
  assign opb  = (ir == 8'hE9) ? ~D_in : D_in;
  assign sum  = {1'b0, a} + {1'b0, opb} + {8'h00, c_flag};
  assign diff = {1'b0, a} - {1'b0, D_in};
  assign D_out = a;

  always_comb begin
    state_nx = state;
    pc_nx    = pc;
    a_nx     = a;
    ir_nx    = ir;
    c_nx     = c_flag;
    z_nx     = z_flag;
    n_nx     = n_flag;
    v_nx     = v_flag;
    RW       = 1'b1;
    AD       = pc;
    res      = 8'h00;
    set_nz   = 1'b0;
    case (state)
      FETCH: begin
        pc_nx    = pc + 16'd1;
        state_nx = DECODE;
      end
      DECODE: begin
        ir_nx = D_in;
        if (two_byte(D_in)) begin
          state_nx = EXEC;
        end else begin
          state_nx = FETCH;
          if (D_in == 8'h18) c_nx = 1'b0;
          if (D_in == 8'h38) c_nx = 1'b1;
        end
      end
      default: begin
        pc_nx    = pc + 16'd1;
        state_nx = FETCH;
        set_nz   = 1'b1;
        case (ir)
          8'hA9: begin res = D_in; a_nx = res; end
          8'h69, 8'hE9: begin
            res  = sum[7:0];
            a_nx = res;
            c_nx = sum[8];
            v_nx = (a[7] == opb[7]) && (sum[7] != a[7]);
          end
          8'h29: begin res = a & D_in; a_nx = res; end
          8'h09: begin res = a | D_in; a_nx = res; end
          8'h49: begin res = a ^ D_in; a_nx = res; end
          8'hC9: begin res = diff[7:0]; c_nx = ~diff[8]; end
          default: begin
            set_nz = 1'b0;
            AD     = {8'h00, D_in};
            RW     = 1'b0;
          end
        endcase
        if (set_nz) begin
          z_nx = (res == 8'h00);
          n_nx = res[7];
        end
      end
    endcase
  end

endmodule

module ram #(
  parameter int ADDR_BITS = 10
) (
  input  logic        clk,
  input  logic        RW,
  input  logic [15:0] AD,
  input  logic [7:0]  D_in,
  output logic [7:0]  D_out
);

  logic [7:0] mem [0:(1 << ADDR_BITS) - 1];
  logic       unused_ad_hi;

  // Upper address bits alias onto the decoded range.
  assign unused_ad_hi = ^AD[15:ADDR_BITS];

  always_ff @(posedge clk) begin
    if (!RW) mem[AD[ADDR_BITS-1:0]] <= D_in;
    D_out <= mem[AD[ADDR_BITS-1:0]];
  end

endmodule

module cpu_core #(
  parameter logic [15:0] RESET_PC  = 16'h0000,
  parameter int          ADDR_BITS = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        rw,
  output logic [15:0] ad,
  output logic [7:0]  wdata
);

  logic [7:0] rdata;

  core #(.RESET_PC(RESET_PC)) u_core (
    .clk   (clk),
    .rst_n (rst_n),
    .RW    (rw),
    .AD    (ad),
    .D_in  (rdata),
    .D_out (wdata)
  );

  ram #(.ADDR_BITS(ADDR_BITS)) u_ram (
    .clk   (clk),
    .RW    (rw),
    .AD    (ad),
    .D_in  (wdata),
    .D_out (rdata)
  );

endmodule

// File: tb/tb_cpu_core.sv
// tb/tb_cpu_core.sv - bench for cpu_core: directed program checks plus random programs
// against an instruction-level reference model.

module tb_cpu_core;

  logic        clk;
  logic        rst_n;
  logic        rw;
  logic [15:0] ad;
  logic [7:0]  wdata;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0]  prog[$];
  logic [7:0]  m_mem [1024];
  logic [15:0] m_pc;
  logic [7:0]  m_a;
  logic        m_c, m_z, m_n, m_v;
  logic [7:0]  ops [11];

  cpu_core dut (
    .clk   (clk),
    .rst_n (rst_n),
    .rw    (rw),
    .ad    (ad),
    .wdata (wdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] dut_flags();
    return {dut.u_core.n_flag, dut.u_core.v_flag, dut.u_core.z_flag, dut.u_core.c_flag};
  endfunction

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic p(input logic [7:0] b);
    prog.push_back(b);
  endtask

  // Holds reset, loads prog into RAM and model, releases reset mid-cycle.
  task automatic start();
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < 1024; i++) begin
      dut.u_ram.mem[i] = 8'h00;
      m_mem[i] = 8'h00;
    end
    for (int i = 0; i < prog.size(); i++) begin
      dut.u_ram.mem[i] = prog[i];
      m_mem[i] = prog[i];
    end
    prog.delete();
    m_pc = 16'h0000; m_a = 8'h00;
    m_c = 1'b0; m_z = 1'b0; m_n = 1'b0; m_v = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic model_exec(output int ncyc, output bit sta, output logic [15:0] sta_ad);
    logic [7:0] opc, opd;
    int s;
    opc = m_mem[m_pc[9:0]];
    m_pc = m_pc + 16'd1;
    opd = 8'h00;
    sta = 1'b0;
    sta_ad = 16'h0000;
    ncyc = 2;
    if (opc inside {8'hA9, 8'h69, 8'hE9, 8'h29, 8'h09, 8'h49, 8'hC9, 8'h85}) begin
      ncyc = 3;
      opd = m_mem[m_pc[9:0]];
      m_pc = m_pc + 16'd1;
    end
    case (opc)
      8'h18: m_c = 1'b0;
      8'h38: m_c = 1'b1;
      8'hA9, 8'h29, 8'h09, 8'h49: begin
        if (opc == 8'hA9) m_a = opd;
        else if (opc == 8'h29) m_a = m_a & opd;
        else if (opc == 8'h09) m_a = m_a | opd;
        else m_a = m_a ^ opd;
        m_z = (m_a == 8'h00); m_n = m_a[7];
      end
      8'h69, 8'hE9: begin
        if (opc == 8'hE9) opd = ~opd;
        s = m_a + opd + m_c;
        m_v = (m_a[7] == opd[7]) && (s[7] != m_a[7]);
        m_c = (s > 255);
        m_a = s[7:0];
        m_z = (m_a == 8'h00); m_n = m_a[7];
      end
      8'hC9: begin
        m_c = (m_a >= opd);
        s = (m_a - opd) & 255;
        m_z = (s == 0); m_n = s[7];
      end
      8'h85: begin
        m_mem[opd] = m_a;
        sta = 1'b1;
        sta_ad = {8'h00, opd};
      end
      default: ;
    endcase
  endtask

  initial begin
    int ncyc, diffs;
    bit sta;
    logic [15:0] sta_ad;

    ops = '{8'hEA, 8'h18, 8'h38, 8'hA9, 8'h69, 8'hE9, 8'h29, 8'h09, 8'h49, 8'hC9, 8'h85};
    rst_n = 1'b0;
    #1;
    check("rst_ad", ad, 16'h0000);
    check("rst_rw", rw, 1'b1);
    check("rst_a", dut.u_core.a, 8'h00);
    check("rst_flags", dut_flags(), 4'h0);
    check("rst_dout", wdata, 8'h00);

    p(8'hEA); p(8'hA9); p(8'h55); p(8'h69); p(8'h03); p(8'h29); p(8'hF0); p(8'h09); p(8'h05);
    start();
    check("rel_ad0", ad, 16'h0000);
    step(1);  check("rel_ad1", ad, 16'h0001);
    step(4);  check("c5_a", dut.u_core.a, 8'h55);
    step(3);  check("c8_a", dut.u_core.a, 8'h58);
    check("c8_cv", {dut.u_core.c_flag, dut.u_core.v_flag}, 2'b00);
    step(3);  check("c11_a", dut.u_core.a, 8'h50);
    step(3);  check("c14_a", dut.u_core.a, 8'h55);
    step(2);  check("nop_pc0", dut.u_core.pc, 16'd10);
    step(2);  check("nop_pc1", dut.u_core.pc, 16'd11);

    p(8'hA9); p(8'h7F); p(8'h69); p(8'h01); p(8'h38); p(8'hE9); p(8'h80);
    start();
    step(6);  check("ovf_a", dut.u_core.a, 8'h80);
    check("ovf_nvzc", dut_flags(), 4'b1100);
    step(5);  check("sbc_a", dut.u_core.a, 8'h00);
    check("sbc_zc", {dut.u_core.z_flag, dut.u_core.c_flag}, 2'b11);

    p(8'hA9); p(8'h3C); p(8'h85); p(8'h40); p(8'hA9); p(8'h00);
    start();
    step(3);  check("sta_pre_rw", rw, 1'b1);
    step(2);  check("sta_rw", rw, 1'b0);
    check("sta_ad", ad, 16'h0040);
    check("sta_dout", wdata, 8'h3C);
    step(1);  check("sta_rw_after", rw, 1'b1);
    step(3);  check("sta_mem", dut.u_ram.mem[16'h40], 8'h3C);
    check("sta_a", dut.u_core.a, 8'h00);
    check("sta_z", dut.u_core.z_flag, 1'b1);

    p(8'hA9); p(8'h10); p(8'hC9); p(8'h10); p(8'hC9); p(8'h20);
    start();
    step(6);  check("cmp_eq_zc", {dut.u_core.z_flag, dut.u_core.c_flag}, 2'b11);
    step(3);  check("cmp_lt_nc", {dut.u_core.n_flag, dut.u_core.c_flag}, 2'b10);
    check("cmp_a", dut.u_core.a, 8'h10);

    p(8'hA9); p(8'h3C); p(8'h85); p(8'h40);
    start();
    step(5);
    rst_n = 1'b0;
    #1;       check("abort_rw", rw, 1'b1);
    rst_n = 1'b1;
    #1;       check("abort_pc", dut.u_core.pc, 16'h0000);
    check("abort_a", dut.u_core.a, 8'h00);
    step(1);  check("abort_mem", dut.u_ram.mem[16'h40], 8'h00);

    for (int t = 0; t < 4; t++) begin
      for (int i = 0; i < 300; i++) begin
        if ($urandom_range(0, 1) == 0) p(ops[$urandom_range(0, 10)]);
        else p(8'($urandom));
      end
      start();
      for (int k = 0; k < 80; k++) begin
        model_exec(ncyc, sta, sta_ad);
        step(2);
        if (sta) begin
          check("rnd_sta_rw", rw, 1'b0);
          check("rnd_sta_ad", ad, sta_ad);
          check("rnd_sta_d", wdata, m_a);
        end
        if (ncyc == 3) step(1);
        check("rnd_pc", dut.u_core.pc, m_pc);
        check("rnd_a", dut.u_core.a, m_a);
        check("rnd_flags", dut_flags(), {m_n, m_v, m_z, m_c});
      end
      diffs = 0;
      for (int i = 0; i < 1024; i++)
        if (dut.u_ram.mem[i] !== m_mem[i]) diffs++;
      check("rnd_mem_diffs", diffs, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
